// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: descriptor handshake, instruction-memory write port and session status
interface instr_encoder_loader_if #(parameter int ADDR_W = 8);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op_class;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_cause;
    logic [ADDR_W:0]   count;

    modport master (
        output start, in_valid, op_class, rs, rt, rd, imm, target, last,
        input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, err_cause, count
    );
    modport slave (
        input  start, in_valid, op_class, rs, rt, rd, imm, target, last,
        output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, err_cause, count
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes instruction descriptors into MIPS words and writes them sequentially to imem
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input logic                   i_clk,
    input logic                   i_reset,
    instr_encoder_loader_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCEPT = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;
    localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);

    logic [2:0]        r_state;
    logic              r_in_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [1:0]        r_cause;
    logic [ADDR_W:0]   r_count;
    logic              r_last;
    logic              w_legal;
    logic [5:0]        w_opcode;
    logic [31:0]       w_enc;

    always_comb begin
        w_legal  = bus.op_class <= 3'd5;
        w_opcode = bus.op_class == 3'd0 ? 6'h00 :
                   bus.op_class == 3'd1 ? 6'h02 :
                   bus.op_class == 3'd2 ? 6'h03 :
                   bus.op_class == 3'd3 ? 6'h23 :
                   bus.op_class == 3'd4 ? 6'h2b : 6'h04;
        w_enc    = (bus.op_class == 3'd1 || bus.op_class == 3'd2) ? {w_opcode, bus.target} :
                   bus.op_class == 3'd0 ? {6'h00, bus.rs, bus.rt, bus.rd, 5'd0, 6'h20} :
                   {w_opcode, bus.rs, bus.rt, bus.imm};
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= L_BASE;
            r_wdata    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cause    <= 2'b00;
            r_count    <= '0;
            r_last     <= 1'b0;
        end else begin
            case (r_state)
                S_ACCEPT: if (bus.in_valid) begin
                    r_in_ready <= 1'b0;
                    if (w_legal) begin
                        r_wdata <= w_enc;
                        r_last  <= bus.last;
                        r_we    <= 1'b1;
                        r_state <= S_WRITE;
                    end else begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                        r_cause <= 2'b01;
                        r_busy  <= 1'b0;
                    end
                end
                S_WRITE: begin
                    r_we    <= 1'b0;
                    r_count <= r_count + (ADDR_W+1)'(1);
                    if (r_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_addr  <= r_addr + ADDR_W'(1);
                    end else if (r_addr == '1) begin
                        // top of memory: stop rather than wrap onto earlier words
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                        r_cause <= 2'b10;
                        r_busy  <= 1'b0;
                    end else begin
                        r_addr     <= r_addr + ADDR_W'(1);
                        r_in_ready <= 1'b1;
                        r_state    <= S_ACCEPT;
                    end
                end
                default: if (bus.start) begin
                    r_state    <= S_ACCEPT;
                    r_in_ready <= 1'b1;
                    r_addr     <= L_BASE;
                    r_count    <= '0;
                    r_done     <= 1'b0;
                    r_err      <= 1'b0;
                    r_cause    <= 2'b00;
                    r_busy     <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.err_cause  = r_cause;
    assign bus.count      = r_count;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed sessions against a queue-based write model, on an 8-bit and a 2-bit address DUT
module tb_instr_encoder_loader;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    logic start_a = 0, start_b = 0, valid_a = 0, valid_b = 0, last = 0;
    logic [2:0] op = 0;
    logic [4:0] rs = 0, rt = 0, rd = 0;
    logic [15:0] imm = 0;
    logic [25:0] tgt = 0;

    instr_encoder_loader_if #(.ADDR_W(8)) a();
    instr_encoder_loader_if #(.ADDR_W(2)) b();

    assign a.start = start_a;  assign a.in_valid = valid_a; assign a.op_class = op;
    assign a.rs = rs; assign a.rt = rt; assign a.rd = rd; assign a.imm = imm;
    assign a.target = tgt; assign a.last = last;
    assign b.start = start_b;  assign b.in_valid = valid_b; assign b.op_class = op;
    assign b.rs = rs; assign b.rt = rt; assign b.rd = rd; assign b.imm = imm;
    assign b.target = tgt; assign b.last = last;

    instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (.i_clk(clk), .i_reset(rst_n), .bus(a));
    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (.i_clk(clk), .i_reset(rst_n), .bus(b));

    int errors = 0, checks = 0;
    logic [39:0] q_a[$], q_b[$];
    logic [39:0] e_a, e_b;
    int m_addr_a = 0, m_addr_b = 0, wr_a = 0, wr_b = 0;
    logic [31:0] mem_a[256];
    logic [31:0] mem_b[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [2:0] o, input logic [4:0] s, t, d,
                                        input logic [15:0] im, input logic [25:0] tg);
        case (o)
            3'd0:    return {6'b000000, s, t, d, 5'b00000, 6'b100000};
            3'd1:    return {6'b000010, tg};
            3'd2:    return {6'b000011, tg};
            3'd3:    return {6'b100011, s, t, im};
            3'd4:    return {6'b101011, s, t, im};
            default: return {6'b000100, s, t, im};
        endcase
    endfunction

    // every write strobe must match the next queued expectation, with in_ready low
    always @(negedge clk) begin
        if (a.imem_we) begin
            wr_a++;
            chk("a_ready_in_write", 32'(a.in_ready), 0);
            if (q_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_write: addr 0x%0h data 0x%08h", a.imem_addr, a.imem_wdata);
            end else begin
                e_a = q_a.pop_front();
                chk("a_waddr", 32'(a.imem_addr), 32'(e_a[39:32]));
                chk("a_wdata", a.imem_wdata, e_a[31:0]);
            end
            mem_a[a.imem_addr] = a.imem_wdata;
        end
        if (b.imem_we) begin
            wr_b++;
            chk("b_ready_in_write", 32'(b.in_ready), 0);
            if (q_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_write: addr 0x%0h data 0x%08h", b.imem_addr, b.imem_wdata);
            end else begin
                e_b = q_b.pop_front();
                chk("b_waddr", 32'(b.imem_addr), 32'(e_b[39:32]));
                chk("b_wdata", b.imem_wdata, e_b[31:0]);
            end
            mem_b[b.imem_addr] = b.imem_wdata;
        end
    end

    task automatic send(input bit sel, input logic [2:0] o, input logic [4:0] s, t, d,
                        input logic [15:0] im, input logic [25:0] tg, input logic l,
                        input int budget, output bit ok);
        op = o; rs = s; rt = t; rd = d; imm = im; tgt = tg; last = l; ok = 0;
        if (sel) valid_b = 1; else valid_a = 1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sel ? b.in_ready : a.in_ready) begin ok = 1; break; end
        end
        if (ok) begin
            if (o <= 3'd5) begin
                if (sel) begin q_b.push_back({8'(m_addr_b), enc(o, s, t, d, im, tg)}); m_addr_b++; end
                else     begin q_a.push_back({8'(m_addr_a), enc(o, s, t, d, im, tg)}); m_addr_a++; end
            end
            @(posedge clk); #1;
        end
        valid_a = 0; valid_b = 0;
    endtask

    task automatic go(input bit sel, input logic [2:0] o, input logic [4:0] s, t, d,
                      input logic [15:0] im, input logic [25:0] tg, input logic l);
        bit ok;
        send(sel, o, s, t, d, im, tg, l, 20, ok);
        chk("handshake", 32'(ok), 1);
    endtask

    task automatic begin_sess(input bit sel);
        if (sel) start_b = 1; else start_a = 1;
        @(posedge clk); #1;
        start_a = 0; start_b = 0;
        if (sel) m_addr_b = 0; else m_addr_a = 0;
        chk("sess_ready", 32'(sel ? b.in_ready : a.in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        rst_n = 0; start_a = 1; start_b = 1; valid_a = 1; valid_b = 1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_in_ready_a", 32'(a.in_ready), 0);
            chk("rst_in_ready_b", 32'(b.in_ready), 0);
        end
        chk("rst_we", 32'(a.imem_we), 0);
        chk("rst_addr", 32'(a.imem_addr), 0);
        chk("rst_wdata", a.imem_wdata, 0);
        chk("rst_busy", 32'(a.busy), 0);
        chk("rst_done", 32'(a.done), 0);
        chk("rst_err", 32'(a.err), 0);
        chk("rst_cause", 32'(a.err_cause), 0);
        chk("rst_count", 32'(a.count), 0);
        start_a = 0; start_b = 0; valid_a = 0; valid_b = 0; rst_n = 1;
        @(posedge clk); #1;
        chk("idle_busy", 32'(a.busy), 0);

        begin_sess(0);
        chk("s1_busy", 32'(a.busy), 1);
        go(0, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 0);
        go(0, 3'd3, 5'd29, 5'd8, 5'd0, 16'h4, 26'h0, 1);
        @(posedge clk); #1;
        chk("s1_done", 32'(a.done), 1);
        chk("s1_busy_end", 32'(a.busy), 0);
        chk("s1_err", 32'(a.err), 0);
        chk("s1_count", 32'(a.count), 2);
        chk("s1_addr", 32'(a.imem_addr), 2);
        chk("s1_pulses", 32'(wr_a), 2);
        chk("s1_word0", mem_a[0], 32'h00221820);
        chk("s1_word1", mem_a[1], 32'h8FA80004);
        chk("s1_ready_done", 32'(a.in_ready), 0);

        begin_sess(0);
        chk("s2_done_clr", 32'(a.done), 0);
        chk("s2_count_clr", 32'(a.count), 0);
        chk("s2_addr_base", 32'(a.imem_addr), 0);
        go(0, 3'd1, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 0);
        go(0, 3'd2, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 0);
        go(0, 3'd5, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 0);
        go(0, 3'd4, 5'd29, 5'd8, 5'd0, 16'h8, 26'h0, 1);
        @(posedge clk); #1;
        chk("s2_done", 32'(a.done), 1);
        chk("s2_count", 32'(a.count), 4);
        chk("s2_pulses", 32'(wr_a), 6);
        chk("s2_word0", mem_a[0], 32'h08000010);
        chk("s2_word1", mem_a[1], 32'h0C000010);
        chk("s2_word2", mem_a[2], 32'h1022FFFF);
        chk("s2_word3", mem_a[3], 32'hAFA80008);

        begin_sess(0);
        go(0, 3'd0, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 0);
        send(0, 3'd6, 5'd7, 5'd7, 5'd7, 16'h7, 26'h7, 0, 20, ok);
        chk("ill_accepted", 32'(ok), 1);
        chk("ill_err", 32'(a.err), 1);
        chk("ill_cause", 32'(a.err_cause), 1);
        chk("ill_count", 32'(a.count), 1);
        chk("ill_busy", 32'(a.busy), 0);
        chk("ill_wdata_kept", a.imem_wdata, 32'h00853020);
        repeat (4) @(posedge clk);
        #1;
        chk("ill_pulses", 32'(wr_a), 7);
        chk("ill_err_held", 32'(a.err), 1);
        begin_sess(0);
        chk("restart_err_clr", 32'(a.err), 0);
        chk("restart_cause_clr", 32'(a.err_cause), 0);
        chk("restart_addr", 32'(a.imem_addr), 0);
        go(0, 3'd4, 5'd1, 5'd2, 5'd0, 16'h1234, 26'h0, 1);
        @(posedge clk); #1;
        chk("restart_done", 32'(a.done), 1);
        chk("restart_word0", mem_a[0], 32'hAC221234);

        begin_sess(0);
        go(0, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 0);
        @(posedge clk); #1;
        start_a = 1;
        @(posedge clk); #1;
        start_a = 0;
        chk("mid_start_addr", 32'(a.imem_addr), 1);
        chk("mid_start_count", 32'(a.count), 1);
        chk("mid_start_busy", 32'(a.busy), 1);
        go(0, 3'd3, 5'd9, 5'd10, 5'd0, 16'h20, 26'h0, 0);
        rst_n = 0;
        @(posedge clk); #1;
        chk("rst_write_we", 32'(a.imem_we), 0);
        chk("rst_write_count", 32'(a.count), 0);
        chk("rst_write_busy", 32'(a.busy), 0);
        chk("rst_write_ready", 32'(a.in_ready), 0);
        chk("rst_write_addr", 32'(a.imem_addr), 0);
        rst_n = 1;
        @(posedge clk); #1;
        chk("rst_write_idle", 32'(a.in_ready), 0);

        begin_sess(1);
        for (int i = 0; i < 4; i++) go(1, 3'd0, 5'(i), 5'd0, 5'(i), 16'h0, 26'h0, 0);
        @(posedge clk); #1;
        chk("ovf_err", 32'(b.err), 1);
        chk("ovf_cause", 32'(b.err_cause), 2);
        chk("ovf_count", 32'(b.count), 4);
        chk("ovf_addr_hold", 32'(b.imem_addr), 3);
        chk("ovf_busy", 32'(b.busy), 0);
        send(1, 3'd0, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 0, 10, ok);
        chk("ovf_fifth_refused", 32'(ok), 0);
        chk("ovf_pulses", 32'(wr_b), 4);
        chk("ovf_word3", mem_b[3], 32'h00601820);
        chk("ovf_queue_empty", 32'(q_b.size()), 0);
        chk("a_queue_empty", 32'(q_a.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Program loader that encodes instruction descriptors (operation class plus register, immediate and target fields) into 32-bit MIPS instruction words. It writes them sequentially into instruction memory through a single write port. It is the encode side of the main decoder: every word it emits uses one of the opcodes the control unit decodes (add, j, jal, lw, sw, beq). It sits between the testbench/boot source and the instruction memory, ahead of the datapath.

## Interface
- ADDR_W, 8, instruction memory word-address width
- BASE_ADDR, 0, first word address written after each start (must be < 2^ADDR_W)

- clk  in  1  clock; all logic rising-edge
- reset  in  1  synchronous, active-low reset
- start  in  1  begin a load session (sampled only in IDLE, DONE, ERR)
- in_valid  in  1  descriptor valid
- in_ready  out  1  loader accepts descriptor this cycle
- op_class  in  3  0=add(R-type), 1=j, 2=jal, 3=lw, 4=sw, 5=beq, 6/7=illegal
- rs, rt, rd  in  5 each  register fields
- imm  in  16  immediate / branch offset, passed through unmodified
- target  in  26  jump target field
- last  in  1  descriptor is final word of program
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  ADDR_W  write word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  session in progress
- done  out  1  session completed normally
- err  out  1  session aborted
- err_cause  out  2  01=illegal op_class, 10=address overflow, 00=none
- count  out  ADDR_W+1  words written this session

## Operation
- States: IDLE, ACCEPT, WRITE, DONE, ERR. All outputs registered.
- Reset values: state IDLE, in_ready 0, imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, busy 0, done 0, err 0, err_cause 00, count 0.
- IDLE/DONE/ERR with start=1 -> ACCEPT. On this transition: imem_addr=BASE_ADDR, count=0, done=0, err=0, err_cause=00, busy=1.
- ACCEPT: in_ready=1. On in_valid&in_ready, encode into imem_wdata and latch last:
  - add: {000000, rs, rt, rd, 00000, 100000}
  - j: {000010, target}
  - jal: {000011, target}
  - lw: {100011, rs, rt, imm}
  - sw: {101011, rs, rt, imm}
  - beq: {000100, rs, rt, imm}
  - Unused fields are ignored.
- Accepting a legal op -> WRITE. Accepting an illegal op (6/7) -> ERR, with err_cause=01, no write, and imem_wdata unchanged.
- WRITE: imem_we=1 for exactly one cycle at the current imem_addr. Leaving WRITE, count+=1.
  - If the latched last=1 -> DONE (done=1, busy=0). imem_addr increments.
  - Else if imem_addr = 2^ADDR_W-1 -> ERR (err=1, err_cause=10, busy=0). imem_addr holds; it does not wrap.
  - Else imem_addr+=1 and -> ACCEPT.
- DONE/ERR: flags held until next start or reset. in_ready=0 and imem_we=0.
- start in ACCEPT or WRITE is ignored.
- reset=0 in any state -> reset values at that edge. A pending write is dropped.

## Timing
- start sampled at edge t in IDLE -> in_ready=1 from t+1.
- Handshake at edge k -> imem_we=1, with valid addr/wdata, during cycle k+1 to k+2.
- in_ready=0 during WRITE. Throughput is 1 word per 2 cycles.
- Last write at cycle k+1 -> done=1 from edge k+2.
- Illegal op accepted at edge k -> err=1 from edge k+1; imem_we never asserted.
- in_valid held while in_ready=0 is not consumed; descriptor fields must stay stable until the handshake.

## Test plan
- Reset with start=1, in_valid=1 -> all outputs at reset values; in_ready stays 0 while reset=0.
- Start, then send add rs=1 rt=2 rd=3 then lw rs=29 rt=8 imm=4 last=1 -> writes 0x00221820 at addr 0, then 0x8FA80004 at addr 1; done=1, count=2, one imem_we pulse per word.
- Session of j target=0x10, jal target=0x10, beq rs=1 rt=2 imm=0xFFFF, sw rs=29 rt=8 imm=8 last=1 -> 0x08000010, 0x0C000010, 0x1022FFFF, 0xAFA80008 at addrs 0-3; count=4.
- op_class=6 as the second descriptor -> first word written; err=1, err_cause=01, count=1; no further imem_we. Then start -> err clears and a new session begins at BASE_ADDR.
- ADDR_W=2, BASE_ADDR=0, four descriptors with last=0 -> writes at addrs 0-3, then err=1, err_cause=10, count=4; fifth in_valid is never accepted.
- reset=0 during WRITE of the second word -> imem_we=0 the next cycle, state IDLE, count=0; start mid-session is ignored.
